// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/LS memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_LS = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
    } tag_t;

    localparam tag_t TAG_NONE = '{valid: 1'b0, owner: 1'b0};

    // Drop a tag's valid bit when a fetch redirect kills in-flight IF reads
    function automatic tag_t kill_if_tag(input tag_t t, input logic kill);
        tag_t r;
        r = t;
        if (kill && (t.owner == OWNER_IF)) begin
            r.valid = 1'b0;
        end else begin
            r.valid = t.valid;
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// MEM_LAT-deep {valid, owner} shift register that tracks outstanding reads;
// a kill strips IF ownership from every in-flight stage, including the output.
module arb_tag_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_kill_if,
    input  tag_t i_push,
    output tag_t o_tag
);

    tag_t r_tags [DEPTH];

    // Advance every stage each cycle; the freshly pushed tag is never killed
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tags[i] <= TAG_NONE;
            end
        end else begin
            r_tags[0] <= i_push;
            for (int i = 1; i < DEPTH; i++) begin
                r_tags[i] <= kill_if_tag(r_tags[i-1], i_kill_if);
            end
        end
    end

    assign o_tag = kill_if_tag(r_tags[DEPTH-1], i_kill_if);

endmodule

// File: rtl/mem_port_arbiter_chk.sv
// Simulation-only protocol checks for the arbiter's requester interfaces.
module mem_port_arbiter_chk #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input logic              i_clk,
    input logic              i_rst,
    input logic              i_if_req,
    input logic [ADDR_W-1:0] i_if_addr,
    input logic              i_if_gnt,
    input logic              i_ls_req,
    input logic              i_ls_we,
    input logic [ADDR_W-1:0] i_ls_addr,
    input logic [DATA_W-1:0] i_ls_wdata,
    input logic              i_ls_gnt
);

    a_if_hold: assert property (@(posedge i_clk) disable iff (i_rst)
        (!i_rst && i_if_req && !i_if_gnt) |=> (i_if_req && $stable(i_if_addr)));

    a_ls_hold: assert property (@(posedge i_clk) disable iff (i_rst)
        (!i_rst && i_ls_req && !i_ls_gnt) |=>
            (i_ls_req && $stable(i_ls_addr) && $stable(i_ls_we) && $stable(i_ls_wdata)));

    a_one_gnt: assert property (@(posedge i_clk) !(i_if_gnt && i_ls_gnt));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between fetch (IF) and load/store (LS) with IF starvation guard.
// Optional performance counters are enabled by defining ARB_PERF_CNT_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int MEM_LAT      = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
`ifdef ARB_PERF_CNT_EN
    output logic [15:0]       perf_if_stall,
    output logic [15:0]       perf_ls_ops,
`endif
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

    logic [SC_W-1:0]   r_starve_cnt;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_ls_rdata;
    logic              w_if_win;
    logic              w_ls_win;
    logic              w_if_hit;
    logic              w_ls_hit;
    tag_t              w_push_tag;
    tag_t              w_out_tag;

    // LS has priority unless IF has already lost STARVE_LIMIT times in a row
    always_comb begin
        w_if_win = 1'b0;
        w_ls_win = 1'b0;
        if (rst) begin
            w_if_win = 1'b0;
            w_ls_win = 1'b0;
        end else if (if_req && ls_req) begin
            if (r_starve_cnt == STARVE_MAX) begin
                w_if_win = 1'b1;
            end else begin
                w_ls_win = 1'b1;
            end
        end else begin
            w_if_win = if_req;
            w_ls_win = ls_req;
        end
    end

    assign if_gnt = w_if_win;
    assign ls_gnt = w_ls_win;

    // Drive the RAM command from the winner; an idle port parks at zero
    always_comb begin
        mem_en    = w_if_win | w_ls_win;
        mem_we    = w_ls_win & ls_we;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        if (w_ls_win) begin
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
        end else if (w_if_win) begin
            mem_addr  = if_addr;
        end else begin
            mem_addr  = {ADDR_W{1'b0}};
            mem_wdata = {DATA_W{1'b0}};
        end
    end

    // Count consecutive LS wins over a waiting fetch, saturating at the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= {SC_W{1'b0}};
        end else if (w_ls_win && if_req) begin
            if (r_starve_cnt != STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + SC_W'(1);
            end else begin
                r_starve_cnt <= r_starve_cnt;
            end
        end else begin
            r_starve_cnt <= {SC_W{1'b0}};
        end
    end

    always_comb begin
        w_push_tag.valid = w_if_win | (w_ls_win & ~ls_we);
        w_push_tag.owner = w_ls_win ? OWNER_LS : OWNER_IF;
    end

    arb_tag_pipe #(
        .DEPTH (MEM_LAT)
    ) u_tag_pipe (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_kill_if (if_flush),
        .i_push    (w_push_tag),
        .o_tag     (w_out_tag)
    );

    assign w_if_hit = ~rst & w_out_tag.valid & (w_out_tag.owner == OWNER_IF);
    assign w_ls_hit = ~rst & w_out_tag.valid & (w_out_tag.owner == OWNER_LS);

    // Remember the last returned word per requester so the idle side holds its data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_rdata <= {DATA_W{1'b0}};
            r_ls_rdata <= {DATA_W{1'b0}};
        end else begin
            r_if_rdata <= w_if_hit ? mem_rdata : r_if_rdata;
            r_ls_rdata <= w_ls_hit ? mem_rdata : r_ls_rdata;
        end
    end

    // Read data flows through in the tag's cycle; reset forces the return side to zero
    always_comb begin
        if_rvalid = w_if_hit;
        ls_rvalid = w_ls_hit;
        if_rdata  = r_if_rdata;
        ls_rdata  = r_ls_rdata;
        if (rst) begin
            if_rdata = {DATA_W{1'b0}};
            ls_rdata = {DATA_W{1'b0}};
        end else begin
            if_rdata = w_if_hit ? mem_rdata : r_if_rdata;
            ls_rdata = w_ls_hit ? mem_rdata : r_ls_rdata;
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [15:0] r_perf_if_stall;
    logic [15:0] r_perf_ls_ops;

    // Saturating counters for fetch stall cycles and LS grants
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_if_stall <= 16'h0000;
            r_perf_ls_ops   <= 16'h0000;
        end else begin
            if (if_req && !w_if_win && (r_perf_if_stall != 16'hFFFF)) begin
                r_perf_if_stall <= r_perf_if_stall + 16'd1;
            end else begin
                r_perf_if_stall <= r_perf_if_stall;
            end
            if (w_ls_win && (r_perf_ls_ops != 16'hFFFF)) begin
                r_perf_ls_ops <= r_perf_ls_ops + 16'd1;
            end else begin
                r_perf_ls_ops <= r_perf_ls_ops;
            end
        end
    end

    assign perf_if_stall = r_perf_if_stall;
    assign perf_ls_ops   = r_perf_ls_ops;
`endif

    mem_port_arbiter_chk #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_chk (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_if_req   (if_req),
        .i_if_addr  (if_addr),
        .i_if_gnt   (if_gnt),
        .i_ls_req   (ls_req),
        .i_ls_we    (ls_we),
        .i_ls_addr  (ls_addr),
        .i_ls_wdata (ls_wdata),
        .i_ls_gnt   (ls_gnt)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner sequences
// and randomized traffic against a queue-based reference model.
module tb_mem_port_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int LAT = 2;
    localparam int SL  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, if_req, if_flush, ls_req, ls_we;
    logic [AW-1:0] if_addr, ls_addr, mem_addr;
    logic [DW-1:0] ls_wdata, mem_wdata, mem_rdata, if_rdata, ls_rdata;
    logic          if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we;
`ifdef ARB_PERF_CNT_EN
    logic [15:0]   perf_if_stall, perf_ls_ops;
`endif

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef ARB_PERF_CNT_EN
        .perf_if_stall(perf_if_stall), .perf_ls_ops(perf_ls_ops),
`endif
        .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic rst; logic flush; logic if_req; logic [AW-1:0] if_addr;
        logic ls_req; logic ls_we; logic [AW-1:0] ls_addr; logic [DW-1:0] ls_wdata;
    } stim_t;

    typedef struct packed {
        stim_t s; logic e_if; logic e_ls; logic e_en; logic e_we;
        logic [AW-1:0] e_addr; logic [DW-1:0] e_wdata;
    } vec_t;

    typedef struct { int due; bit own_ls; logic [AW-1:0] addr; } ret_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 16;
    int streak  = 0;
    int m_stall = 0;
    int m_ops   = 0;
    ret_t retq[$];
    logic [DW-1:0] m_if_rd = '0, m_ls_rd = '0;
    bit            ram_v [16];
    logic [AW-1:0] ram_a [16];

    // Model results of the latest cycle, used by directed sequences and stimulus
    logic e_if, e_ls;
    logic a_if_gnt, a_ls_gnt, a_if_rv, a_ls_rv, a_mem_en;
    logic [AW-1:0] a_mem_addr;
    logic [DW-1:0] a_if_rd, a_ls_rd;

    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        return a ^ 8'hB5;
    endfunction

    function automatic stim_t mk(input logic r, input logic ir, input logic [AW-1:0] ia,
                                 input logic lr, input logic we, input logic [AW-1:0] la,
                                 input logic [DW-1:0] wd);
        stim_t s;
        s = '{rst: r, flush: 1'b0, if_req: ir, if_addr: ia, ls_req: lr, ls_we: we,
              ls_addr: la, ls_wdata: wd};
        return s;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // One clock: drive inputs, let the RAM model answer, check everything against the model
    task automatic cycle(input stim_t s);
        ret_t r;
        bit got;
        logic [DW-1:0] exp_if_rd, exp_ls_rd;
        @(negedge clk);
        rst = s.rst; if_flush = s.flush;
        if_req = s.if_req; if_addr = s.if_addr;
        ls_req = s.ls_req; ls_we = s.ls_we; ls_addr = s.ls_addr; ls_wdata = s.ls_wdata;
        mem_rdata = ram_v[(cyc - LAT) % 16] ? ram_word(ram_a[(cyc - LAT) % 16]) : DW'($urandom);
        #1;
        if (s.rst) begin
            e_if = 1'b0; e_ls = 1'b0;
        end else if (s.if_req && s.ls_req) begin
            e_ls = (streak < SL); e_if = !e_ls;
        end else begin
            e_if = s.if_req; e_ls = s.ls_req;
        end
        got = 1'b0;
        if (!s.rst) begin
            if (s.flush) begin
                for (int i = retq.size() - 1; i >= 0; i--)
                    if (!retq[i].own_ls) retq.delete(i);
            end
            if (retq.size() > 0 && retq[0].due == cyc) begin
                got = 1'b1; r = retq.pop_front();
            end
        end
        exp_if_rd = s.rst ? '0 : ((got && !r.own_ls) ? ram_word(r.addr) : m_if_rd);
        exp_ls_rd = s.rst ? '0 : ((got &&  r.own_ls) ? ram_word(r.addr) : m_ls_rd);
        a_if_gnt = if_gnt; a_ls_gnt = ls_gnt; a_if_rv = if_rvalid; a_ls_rv = ls_rvalid;
        a_if_rd = if_rdata; a_ls_rd = ls_rdata; a_mem_en = mem_en; a_mem_addr = mem_addr;
        chk("if_gnt", if_gnt, e_if);
        chk("ls_gnt", ls_gnt, e_ls);
        chk("mem_en", mem_en, e_if | e_ls);
        chk("mem_we", mem_we, e_ls & s.ls_we);
        chk("mem_addr", mem_addr, e_ls ? s.ls_addr : (e_if ? s.if_addr : '0));
        chk("mem_wdata", mem_wdata, e_ls ? s.ls_wdata : '0);
        chk("if_rvalid", if_rvalid, got && !r.own_ls);
        chk("ls_rvalid", ls_rvalid, got && r.own_ls);
        chk("if_rdata", if_rdata, exp_if_rd);
        chk("ls_rdata", ls_rdata, exp_ls_rd);
`ifdef ARB_PERF_CNT_EN
        chk("perf_if_stall", perf_if_stall, 16'(m_stall));
        chk("perf_ls_ops", perf_ls_ops, 16'(m_ops));
`endif
        if (s.rst) begin
            retq.delete(); streak = 0; m_if_rd = '0; m_ls_rd = '0; m_stall = 0; m_ops = 0;
        end else begin
            m_if_rd = exp_if_rd; m_ls_rd = exp_ls_rd;
            streak = (e_ls && s.if_req) ? ((streak < SL) ? streak + 1 : SL) : 0;
            if (s.if_req && !e_if && m_stall < 65535) m_stall++;
            if (e_ls && m_ops < 65535) m_ops++;
            if (e_if) retq.push_back('{due: cyc + LAT, own_ls: 1'b0, addr: s.if_addr});
            if (e_ls && !s.ls_we) retq.push_back('{due: cyc + LAT, own_ls: 1'b1, addr: s.ls_addr});
        end
        ram_v[cyc % 16] = mem_en && !mem_we;
        ram_a[cyc % 16] = mem_addr;
        cyc++;
    endtask

    vec_t  tbl [8];
    stim_t st;
    stim_t idle;
    logic [7:0] seq;
    int cnt;

    initial begin
        idle = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        tbl[0] = '{mk(1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 8'h33), 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[1] = '{mk(1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00), 1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00};
        tbl[2] = '{mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 8'h00), 1'b0, 1'b1, 1'b1, 1'b0, 8'h33, 8'h00};
        tbl[3] = '{mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 8'h3C), 1'b0, 1'b1, 1'b1, 1'b1, 8'h20, 8'h3C};
        tbl[4] = '{mk(1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 8'h55, 8'h00), 1'b0, 1'b1, 1'b1, 1'b0, 8'h55, 8'h00};
        tbl[5] = '{mk(1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 8'hFF, 8'hFF), 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF};
        tbl[6] = '{mk(1'b0, 1'b0, 8'h7E, 1'b0, 1'b1, 8'h7F, 8'h99), 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[7] = '{mk(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00), 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h00};

        st = idle;
        for (int i = 0; i < 8; i++) begin
            st.rst = 1'b1;
            cycle(st);
            cycle(tbl[i].s);
            chk("tbl_if_gnt", a_if_gnt, tbl[i].e_if);
            chk("tbl_ls_gnt", a_ls_gnt, tbl[i].e_ls);
            chk("tbl_mem_en", a_mem_en, tbl[i].e_en);
            chk("tbl_mem_addr", a_mem_addr, tbl[i].e_addr);
            st = tbl[i].s;
        end

        // Fetch only: RAM word 0xA5 returns two cycles after the grant
        st.rst = 1'b1; cycle(st);
        cycle(mk(1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00));
        chk("fetch_gnt", a_if_gnt, 1'b1);
        cycle(idle);
        chk("fetch_early", a_if_rv, 1'b0);
        cycle(idle);
        chk("fetch_rvalid", a_if_rv, 1'b1);
        chk("fetch_rdata", a_if_rd, 8'hA5);

        // Contention: LS wins three times, then IF is forced through
        cycle(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00));
        st = mk(1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 8'hC0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            cycle(st);
            seq[i] = a_ls_gnt;
            if (e_if) st.if_addr = st.if_addr + 8'd1;
            if (e_ls) st.ls_addr = st.ls_addr + 8'd1;
        end
        chk("contention_seq", seq, 8'b0111_0111);

        // Store: write strobe and data in the grant cycle, no read return later
        cycle(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00));
        cycle(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 8'h3C));
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(idle);
            cnt += a_ls_rv;
        end
        chk("store_no_rvalid", cnt, 0);

        // Flush: two fetches in flight die, the redirected fetch returns
        cycle(mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00));
        cycle(mk(1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00));
        st = mk(1'b0, 1'b1, 8'h40, 1'b0, 1'b0, 8'h00, 8'h00);
        st.flush = 1'b1;
        cycle(st);
        cnt = a_if_rv;
        cycle(idle); cnt += a_if_rv;
        cycle(idle); cnt += a_if_rv;
        chk("flush_new_rdata", a_if_rd, 8'hF5);
        cycle(idle); cnt += a_if_rv;
        chk("flush_rvalid_cnt", cnt, 1);

        // Mixed order: load then fetch, returns in issue order on separate cycles
        cycle(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h05, 8'h00));
        cycle(mk(1'b0, 1'b1, 8'h06, 1'b0, 1'b0, 8'h00, 8'h00));
        cycle(idle);
        chk("mixed_t2", {a_ls_rv, a_if_rv}, 2'b10);
        cycle(idle);
        chk("mixed_t3", {a_ls_rv, a_if_rv}, 2'b01);

        // Reset one cycle after a load grant drops the load's return
        cycle(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h05, 8'h00));
        cycle(mk(1'b1, 1'b1, 8'h09, 1'b1, 1'b0, 8'h07, 8'h00));
        chk("rst_outputs", {a_if_gnt, a_ls_gnt, a_mem_en, a_if_rv, a_ls_rv, a_mem_addr, a_if_rd, a_ls_rd}, 0);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(idle);
            cnt += a_ls_rv;
        end
        chk("rst_no_rvalid", cnt, 0);
        cycle(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h0A, 8'h00));
        chk("rst_first_gnt", a_ls_gnt, 1'b1);

        // Randomized traffic with held requests, flushes and occasional resets
        st = idle;
        for (int i = 0; i < 800; i++) begin
            st.rst   = ($urandom_range(0, 59) == 0);
            st.flush = ($urandom_range(0, 9) == 0);
            cycle(st);
            if (e_if || !st.if_req) begin
                st.if_req  = ($urandom_range(0, 9) < 6);
                st.if_addr = AW'($urandom);
            end
            if (e_ls || !st.ls_req) begin
                st.ls_req   = ($urandom_range(0, 9) < 5);
                st.ls_we    = $urandom_range(0, 1);
                st.ls_addr  = AW'($urandom);
                st.ls_wdata = DW'($urandom);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single-port data/instruction RAM between the fetch unit (IF) and the load/store unit (LS).
- Issues at most one memory access per cycle and returns read data to the correct requester after a fixed memory latency.
- Guarantees fetch forward progress with a starvation limit.
- Sits between the core's IF/LS stages and the RAM inside the complete-processor top level.

Parameters:
ADDR_W, 8, address width in bits
DATA_W, 8, data width in bits
MEM_LAT, 2, RAM read latency in cycles (>=1); read data is valid MEM_LAT cycles after the command cycle
STARVE_LIMIT, 3, maximum consecutive LS wins while IF is waiting before IF is forced to win (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request; held until granted
if_addr  in  ADDR_W  fetch address
if_flush  in  1  branch/redirect: discard all in-flight fetch reads
if_gnt  out  1  fetch request accepted this cycle (combinational)
if_rvalid  out  1  fetch read data valid
if_rdata  out  DATA_W  fetch read data
ls_req  in  1  load/store request; held until granted
ls_we  in  1  1 = store, 0 = load
ls_addr  in  ADDR_W  load/store address
ls_wdata  in  DATA_W  store data
ls_gnt  out  1  load/store request accepted this cycle (combinational)
ls_rvalid  out  1  load data valid
ls_rdata  out  DATA_W  load data
mem_en  out  1  RAM command valid
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid MEM_LAT cycles after a read command

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - All registered state cleared: starvation counter = 0, tag pipeline all invalid.
  - While rst is high: if_gnt = ls_gnt = mem_en = mem_we = 0, rvalids = 0, rdata = 0, mem_addr = 0, mem_wdata = 0.
- Arbitration (combinational, same cycle):
  - Only ls_req: LS granted.
  - Only if_req: IF granted.
  - Both high: LS wins unless starve_cnt == STARVE_LIMIT, in which case IF wins.
  - Never both grants in one cycle.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when LS is granted while if_req is high.
  - Clears when IF is granted or when if_req is low.
- Memory command:
  - mem_en = if_gnt | ls_gnt.
  - mem_addr and mem_wdata come from the winner; mem_wdata = 0 for fetch.
  - mem_we = ls_gnt & ls_we; fetches are always reads.
  - When idle, mem_addr and mem_wdata hold 0.
- Tag pipeline:
  - MEM_LAT-deep shift register of {valid, owner}.
  - A read grant pushes valid=1 with owner = IF or LS; a write or idle cycle pushes valid=0.
  - At the pipeline output, the owner's rvalid is asserted for exactly one cycle, and its rdata = mem_rdata (registered-through, same cycle as the tag).
  - The non-owner rdata holds its previous value.
- Reads are returned in issue order; at most one rvalid per cycle.
- Flush:
  - if_flush clears the valid bit of every in-flight IF tag, so no if_rvalid appears for those reads.
  - A fetch granted in the same cycle as if_flush is NOT killed; it is the redirected fetch.
  - LS tags are unaffected.
- Reset mid-operation: in-flight reads are dropped; no rvalid is produced for them after rst deasserts.
- Requester contract: req/addr/we/wdata stay stable until gnt; violating this is a protocol error (asserted in simulation, not handled).
- Throughput: one access per cycle; back-to-back loads give back-to-back ls_rvalid.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_if_stall (16 bit) and perf_ls_ops (16 bit).
  - perf_if_stall counts cycles with if_req & ~if_gnt; perf_ls_ops counts LS grants.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent, and the arbiter's behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - owner encoding constants OWNER_IF = 1'b0, OWNER_LS = 1'b1
  - default ADDR_W/DATA_W
  - tag record typedef {valid, owner}
- One natural sub-module: arb_tag_pipe (the MEM_LAT-deep tag shift register with per-owner kill). Arbitration and the starvation counter stay in the top.

Test Plan:
- Fetch only: if_req=1, addr 0x10, RAM returns 0xA5 → if_gnt same cycle, mem_en=1 mem_we=0 mem_addr=0x10, if_rvalid=1 with if_rdata=0xA5 exactly 2 cycles later.
- Contention: if_req and ls_req held high (loads), STARVE_LIMIT=3 → grant sequence LS, LS, LS, IF, LS, LS, LS, IF; starve_cnt never exceeds 3.
- Store: ls_req=1 ls_we=1 addr 0x20 wdata 0x3C → mem_we=1 mem_wdata=0x3C same cycle, no ls_rvalid afterwards.
- Flush: fetches to 0x00 and 0x01 in flight, if_flush pulsed with a new fetch to 0x40 in the same cycle → no if_rvalid for 0x00/0x01, one if_rvalid for 0x40.
- Mixed order: load 0x05 then fetch 0x06 on consecutive cycles → ls_rvalid at T+2, if_rvalid at T+3, never simultaneous.
- Reset mid-flight: rst asserted one cycle after a load grant → all outputs 0 during reset; no ls_rvalid after rst falls; first post-reset request is granted normally.
